// File: rtl/rf_pkg.sv
// Shared constants and types for the LEGv8 register file and its load-use scoreboard.
package rf_pkg;
   localparam int DATA_W   = 64;
   localparam int NUM_REGS = 32;
   localparam int ADDR_W   = $clog2(NUM_REGS);
   localparam int ZERO_REG = 31;

   typedef logic [ADDR_W-1:0] reg_idx_t;
   typedef logic [DATA_W-1:0] word_t;

   localparam reg_idx_t XZR = reg_idx_t'(ZERO_REG);
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for in-flight loads; raises stall when a read operand is pending.
module rf_scoreboard
   import rf_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  reg_idx_t            ra,
   input  reg_idx_t            rb,
   input  logic                issue_valid,
   input  reg_idx_t            issue_rd,
   input  logic                wr_en,
   input  reg_idx_t            wr_idx,
   input  logic [NUM_REGS-1:0] byp_clr,
   output logic                stall
);

   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] eff_busy;
   logic [NUM_REGS-1:0] set_vec;
   logic [NUM_REGS-1:0] clr_vec;

   // Registers retiring this cycle may be masked out when write-through is available.
   assign eff_busy = busy & ~byp_clr;
   assign stall    = (eff_busy[ra] && (ra != XZR)) || (eff_busy[rb] && (rb != XZR));

   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (issue_valid && !stall && (issue_rd != XZR))
         set_vec[issue_rd] = 1'b1;
      if (wr_en && (wr_idx != XZR))
         clr_vec[wr_idx] = 1'b1;
   end

   // Set applied after clear: a new load supersedes the one retiring on the same index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         busy <= '0;
      else
         busy <= (busy & ~clr_vec) | set_vec;
   end

endmodule

// File: rtl/reg_file_sb.sv
// 32 x 64-bit LEGv8 register file with load-use scoreboard.
// Define REG_FILE_BYPASS_EN for write-through forwarding and same-cycle stall release.
module reg_file_sb
   import rf_pkg::*;
(
   input  logic              Clk,
   input  logic              Reset,
   input  logic [ADDR_W-1:0] RA,
   input  logic [ADDR_W-1:0] RB,
   output logic [DATA_W-1:0] BusA,
   output logic [DATA_W-1:0] BusB,
   input  logic [ADDR_W-1:0] RW,
   input  logic [DATA_W-1:0] BusW,
   input  logic              RegWr,
   input  logic              IssueValid,
   input  logic [ADDR_W-1:0] IssueRd,
   output logic              Stall
);

   word_t               regs [NUM_REGS];
   logic                wr_hit;
   logic                fwd_a;
   logic                fwd_b;
   logic [NUM_REGS-1:0] byp_clr;

   assign wr_hit = RegWr && (RW != XZR);

`ifdef REG_FILE_BYPASS_EN
   assign fwd_a = wr_hit && (RA == RW);
   assign fwd_b = wr_hit && (RB == RW);

   always_comb begin
      byp_clr = '0;
      if (wr_hit)
         byp_clr[RW] = 1'b1;
   end
`else
   assign fwd_a   = 1'b0;
   assign fwd_b   = 1'b0;
   assign byp_clr = '0;
`endif

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= '0;
      end else if (wr_hit) begin
         regs[RW] <= BusW;
      end
   end

   // Reset gating keeps forwarded BusW off the buses while Reset is held.
   always_comb begin
      BusA = '0;
      BusB = '0;
      if (!Reset) begin
         if (RA != XZR) BusA = fwd_a ? BusW : regs[RA];
         if (RB != XZR) BusB = fwd_b ? BusW : regs[RB];
      end
   end

   rf_scoreboard u_sb (
      .clk         (Clk),
      .rst         (Reset),
      .ra          (RA),
      .rb          (RB),
      .issue_valid (IssueValid),
      .issue_rd    (IssueRd),
      .wr_en       (RegWr),
      .wr_idx      (RW),
      .byp_clr     (byp_clr),
      .stall       (Stall)
   );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb; expectations follow REG_FILE_BYPASS_EN when defined.
module tb_reg_file_sb;
   import rf_pkg::*;

`ifdef REG_FILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic              Clk = 1'b0;
   logic              Reset;
   logic [ADDR_W-1:0] RA, RB, RW, IssueRd;
   logic [DATA_W-1:0] BusA, BusB, BusW;
   logic              RegWr, IssueValid, Stall;

   int checks = 0;
   int errors = 0;

   reg_file_sb dut (
      .Clk(Clk), .Reset(Reset), .RA(RA), .RB(RB), .BusA(BusA), .BusB(BusB),
      .RW(RW), .BusW(BusW), .RegWr(RegWr), .IssueValid(IssueValid),
      .IssueRd(IssueRd), .Stall(Stall)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      logic [DATA_W-1:0] exp_w;
      Reset = 1'b1; RA = '0; RB = '0; RW = '0; BusW = '0; RegWr = 1'b0;
      IssueValid = 1'b0; IssueRd = '0;
      tick(); tick();
      Reset = 1'b0;
      tick();
      for (int i = 0; i < NUM_REGS; i++) begin
         RA = reg_idx_t'(i); RB = reg_idx_t'(NUM_REGS - 1 - i);
         #1;
         checks++;
         if (BusA !== '0 || BusB !== '0 || Stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_read idx=%0d BusA=%h BusB=%h Stall=%b want 0/0/0", i, BusA, BusB, Stall);
         end
      end
      // Reset asserted while a write is being presented
      RW = 5'd3; BusW = 64'h1111_2222_3333_4444; RegWr = 1'b1; RA = 5'd3; Reset = 1'b1;
      #1;
      checks++;
      if (BusA !== '0) begin
         errors++;
         $display("FAIL reset_hold_busa got=%h want=0", BusA);
      end
      tick();
      Reset = 1'b0; RegWr = 1'b0;
      #1;
      exp_w = '0;
      checks++;
      if (BusA !== exp_w) begin
         errors++;
         $display("FAIL reset_mid_write got=%h want=%h", BusA, exp_w);
      end
   endtask

   task automatic test_write();
      logic [DATA_W-1:0] exp_w;
      RW = 5'd5; BusW = 64'hDEAD_BEEF_0000_1234; RegWr = 1'b1; RA = 5'd5; RB = 5'd0;
      #1;
      exp_w = BYP ? 64'hDEAD_BEEF_0000_1234 : 64'h0;
      checks++;
      if (BusA !== exp_w) begin
         errors++;
         $display("FAIL write_same_cycle got=%h want=%h", BusA, exp_w);
      end
      tick();
      RegWr = 1'b0; RB = 5'd5;
      #1;
      checks++;
      if (BusA !== 64'hDEAD_BEEF_0000_1234 || BusB !== 64'hDEAD_BEEF_0000_1234) begin
         errors++;
         $display("FAIL write_readback BusA=%h BusB=%h want=deadbeef00001234", BusA, BusB);
      end
      RW = 5'd31; BusW = '1; RegWr = 1'b1; RA = 5'd31;
      #1;
      checks++;
      if (BusA !== '0) begin
         errors++;
         $display("FAIL xzr_fwd got=%h want=0", BusA);
      end
      tick();
      RegWr = 1'b0;
      #1;
      checks++;
      if (BusA !== '0) begin
         errors++;
         $display("FAIL xzr_write got=%h want=0", BusA);
      end
   endtask

   task automatic test_load_use();
      RA = 5'd0; RB = 5'd0; IssueValid = 1'b1; IssueRd = 5'd9;
      tick();
      IssueValid = 1'b0; RA = 5'd9;
      #1;
      checks++;
      if (Stall !== 1'b1) begin
         errors++;
         $display("FAIL load_use_stall got=%b want=1", Stall);
      end
      RW = 5'd9; BusW = 64'd7; RegWr = 1'b1;
      #1;
      checks++;
      if (Stall !== !BYP) begin
         errors++;
         $display("FAIL wb_cycle_stall got=%b want=%b", Stall, !BYP);
      end
      checks++;
      if (BusA !== (BYP ? 64'd7 : 64'd0)) begin
         errors++;
         $display("FAIL wb_cycle_busa got=%h want=%h", BusA, (BYP ? 64'd7 : 64'd0));
      end
      tick();
      RegWr = 1'b0;
      #1;
      checks++;
      if (Stall !== 1'b0 || BusA !== 64'd7) begin
         errors++;
         $display("FAIL after_wb Stall=%b BusA=%h want 0/7", Stall, BusA);
      end
   endtask

   task automatic test_set_clear_same();
      RA = 5'd0; RB = 5'd0;
      IssueValid = 1'b1; IssueRd = 5'd12; RegWr = 1'b1; RW = 5'd12; BusW = 64'd3;
      tick();
      IssueValid = 1'b0; RegWr = 1'b0; RB = 5'd12;
      #1;
      checks++;
      if (Stall !== 1'b1) begin
         errors++;
         $display("FAIL set_wins_stall got=%b want=1", Stall);
      end
      checks++;
      if (BusB !== 64'd3) begin
         errors++;
         $display("FAIL set_clear_data got=%h want=3", BusB);
      end
      RegWr = 1'b1; RW = 5'd12; BusW = 64'd3; RB = 5'd0;
      tick();
      RegWr = 1'b0; RB = 5'd12;
      #1;
      checks++;
      if (Stall !== 1'b0) begin
         errors++;
         $display("FAIL clear_12 got=%b want=0", Stall);
      end
   endtask

   task automatic test_issue_while_stall();
      RA = 5'd0; RB = 5'd0; IssueValid = 1'b1; IssueRd = 5'd4;
      tick();
      RA = 5'd4; IssueRd = 5'd6;
      #1;
      checks++;
      if (Stall !== 1'b1) begin
         errors++;
         $display("FAIL stall_reg4 got=%b want=1", Stall);
      end
      tick();
      IssueValid = 1'b0; RA = 5'd0; RB = 5'd6;
      #1;
      checks++;
      if (Stall !== 1'b0) begin
         errors++;
         $display("FAIL issue_ignored got=%b want=0", Stall);
      end
      RB = 5'd0; RA = 5'd4; RegWr = 1'b1; RW = 5'd4; BusW = 64'h44;
      tick();
      RegWr = 1'b0;
      #1;
      checks++;
      if (Stall !== 1'b0 || BusA !== 64'h44) begin
         errors++;
         $display("FAIL clear_4 Stall=%b BusA=%h want 0/44", Stall, BusA);
      end
   endtask

   task automatic test_zero_reg();
      RA = 5'd0; RB = 5'd0; IssueValid = 1'b1; IssueRd = 5'd31;
      tick();
      IssueValid = 1'b0; RA = 5'd31; RB = 5'd31;
      #1;
      checks++;
      if (Stall !== 1'b0 || BusA !== '0 || BusB !== '0) begin
         errors++;
         $display("FAIL xzr_issue Stall=%b BusA=%h BusB=%h want 0/0/0", Stall, BusA, BusB);
      end
   endtask

   task automatic test_reset_busy();
      RA = 5'd0; RB = 5'd0; IssueValid = 1'b1; IssueRd = 5'd20;
      tick();
      IssueValid = 1'b0; RB = 5'd20;
      #1;
      checks++;
      if (Stall !== 1'b1) begin
         errors++;
         $display("FAIL busy_20 got=%b want=1", Stall);
      end
      Reset = 1'b1;
      #1;
      checks++;
      if (Stall !== 1'b0) begin
         errors++;
         $display("FAIL reset_stall got=%b want=0", Stall);
      end
      tick();
      Reset = 1'b0;
      tick();
      checks++;
      if (Stall !== 1'b0 || BusA !== '0) begin
         errors++;
         $display("FAIL post_reset Stall=%b BusA=%h want 0/0", Stall, BusA);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_load_use();
      test_set_clear_same();
      test_issue_while_stall();
      test_zero_reg();
      test_reset_busy();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
